// File: rtl/shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// shift_reg_sequencer
//   Framed serial transfer controller with an embedded left-shift register.
//   A parallel word is accepted through a valid/ready handshake, shifted out
//   MSB-first on SO for a programmable number of bits, while SI is captured
//   into the LSB on every shift tick. The received word appears on dout
//   together with a one-cycle done pulse. Shift cadence is one tick every
//   DIV clock cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start_valid  requester presents a word on din/len
//   start_ready  block can accept a word (IDLE only)
//   din          parallel word to transmit
//   len          bit count; 0 or > WIDTH selects WIDTH
//   abort        synchronous cancel of an active transfer
//   SI           serial input, sampled on shift ticks
//   SO           serial output, registered
//   busy         high while shifting or completing
//   done         one-cycle completion pulse
//   dout         captured word, valid from done onward
// -----------------------------------------------------------------------------
module shift_reg_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             SI,
    output logic             SO,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A zero or oversized request means "shift the whole word".
    function automatic logic [LEN_W-1:0] len_eff_f(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if ((l == {LEN_W{1'b0}}) || (l > WIDTH_L)) begin
            r = WIDTH_L;
        end else begin
            r = l;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           next_s;
    logic [WIDTH-1:0] sr_r;
    logic [LEN_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic             so_r;
    logic             busy_r;
    logic             done_r;
    logic             start_ready_r;
    logic [WIDTH-1:0] dout_r;
    logic             tick_s;
    logic [WIDTH-1:0] shifted_s;

    assign start_ready = start_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign SO          = so_r;
    assign dout        = dout_r;

    // Next-state decode, tick detection and the shifted register image.
    always_comb begin
        next_s    = state_r;
        tick_s    = (state_r == ST_SHIFT) && (div_r == DIV_LAST);
        shifted_s = {sr_r[WIDTH-2:0], SI};
        case (state_r)
            ST_IDLE: begin
                // abort has no meaning before a transfer starts
                if (start_valid) begin
                    next_s = ST_SHIFT;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // abort wins over a coincident tick
                if (abort) begin
                    next_s = ST_IDLE;
                end else if (tick_s && (cnt_r == LEN_W'(1))) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register and state-derived handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            start_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= next_s;
            start_ready_r <= (next_s == ST_IDLE);
            busy_r        <= (next_s != ST_IDLE);
            done_r        <= (next_s == ST_DONE);
        end
    end

    // Shift register, bit counter, divider, serial output and captured word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r   <= {WIDTH{1'b0}};
            cnt_r  <= {LEN_W{1'b0}};
            div_r  <= {DIV_W{1'b0}};
            so_r   <= 1'b0;
            dout_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_valid) begin
                        sr_r  <= din;
                        cnt_r <= len_eff_f(len);
                        div_r <= {DIV_W{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    // An aborted cycle leaves SR, SO and dout untouched.
                    if (!abort) begin
                        if (tick_s) begin
                            so_r  <= sr_r[WIDTH-1];
                            sr_r  <= shifted_s;
                            cnt_r <= cnt_r - LEN_W'(1);
                            div_r <= {DIV_W{1'b0}};
                            // Capture the post-shift image so dout and done
                            // become valid on the same edge.
                            if (cnt_r == LEN_W'(1)) begin
                                dout_r <= shifted_s;
                            end
                        end else begin
                            div_r <= div_r + DIV_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_sequencer
//   Self-checking bench for shift_reg_sequencer. Two instances share the
//   clock and reset: one with DIV=1 and one with DIV=2 (both WIDTH=8,
//   LEN_W=4). Expected SO, dout and handshake values come from a transfer
//   model computed from the bit-count rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_shift_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sv   [2];
    logic       rdy  [2];
    logic [7:0] din  [2];
    logic [3:0] len  [2];
    logic       ab   [2];
    logic       si   [2];
    logic       so   [2];
    logic       bz   [2];
    logic       dn   [2];
    logic [7:0] dout [2];

    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    logic       exp_so   [2];
    logic [7:0] exp_dout [2];
    int         last_accept [2];

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    shift_reg_sequencer #(.WIDTH(8), .DIV(1), .LEN_W(4)) u_div1 (
        .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(rdy[0]),
        .din(din[0]), .len(len[0]), .abort(ab[0]), .SI(si[0]), .SO(so[0]),
        .busy(bz[0]), .done(dn[0]), .dout(dout[0])
    );

    shift_reg_sequencer #(.WIDTH(8), .DIV(2), .LEN_W(4)) u_div2 (
        .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(rdy[1]),
        .din(din[1]), .len(len[1]), .abort(ab[1]), .SI(si[1]), .SO(so[1]),
        .busy(bz[1]), .done(dn[1]), .dout(dout[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input int d, input string tag);
        chk({tag, "_ready"}, rdy[d], 1'b1);
        chk({tag, "_busy"},  bz[d],  1'b0);
        chk({tag, "_done"},  dn[d],  1'b0);
        chk({tag, "_so"},    so[d],  exp_so[d]);
        chk({tag, "_dout"},  dout[d], exp_dout[d]);
    endtask

    // One transfer on instance d. si_bits[k-1] is the SI value for shift k.
    // abort_at: shift number on which abort is raised (0 = never).
    // hold: keep start_valid high for a back-to-back follow-on.
    // ab_edges: raise abort on the accept edge and during DONE (both ignored).
    // gap: required cycles since the previous accept on this instance (0 = skip).
    task automatic xfer(input int d, input logic [7:0] wd, input logic [3:0] ln,
                        input logic [7:0] si_bits, input int abort_at,
                        input bit hold, input bit ab_edges, input int gap);
        int         dv;
        int         leff;
        int         k;
        bit         is_tick;
        logic [7:0] rx;
        dv   = (d == 0) ? 1 : 2;
        leff = ((ln == 4'd0) || (ln > 4'd8)) ? 8 : int'(ln);
        rx   = 8'h00;
        idle_checks(d, "pre");
        sv[d]  = 1'b1;
        din[d] = wd;
        len[d] = ln;
        ab[d]  = ab_edges;
        si[d]  = 1'($urandom_range(0, 1));
        step();
        if (gap != 0) chk("accept_gap", cyc - last_accept[d], gap);
        last_accept[d] = cyc;
        if (!hold) sv[d] = 1'b0;
        ab[d] = 1'b0;
        chk("acc_busy",  bz[d],  1'b1);
        chk("acc_ready", rdy[d], 1'b0);
        chk("acc_done",  dn[d],  1'b0);
        for (int c = 1; c <= leff * dv; c++) begin
            is_tick = ((c % dv) == 0);
            k       = c / dv;
            if (is_tick) begin
                si[d] = si_bits[k-1];
                ab[d] = (k == abort_at);
            end else begin
                si[d] = 1'($urandom_range(0, 1));
                ab[d] = 1'b0;
            end
            step();
            ab[d] = 1'b0;
            if (is_tick && (k == abort_at)) begin
                idle_checks(d, "abort");
                return;
            end
            if (is_tick) begin
                exp_so[d] = wd[8-k];
                rx        = {rx[6:0], si_bits[k-1]};
            end
            chk("sh_so",    so[d],  exp_so[d]);
            chk("sh_done",  dn[d],  (is_tick && (k == leff)) ? 1'b1 : 1'b0);
            chk("sh_busy",  bz[d],  1'b1);
            chk("sh_ready", rdy[d], 1'b0);
        end
        exp_dout[d] = 8'(wd << leff) | rx;
        chk("done_dout", dout[d], exp_dout[d]);
        ab[d] = ab_edges;
        step();
        ab[d] = 1'b0;
        idle_checks(d, "post");
    endtask

    initial begin
        int         d;
        int         ab_at;
        logic [7:0] wd;
        logic [3:0] ln;
        logic [7:0] sib;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; din[i] = 8'h00; len[i] = 4'd0; ab[i] = 1'b0; si[i] = 1'b0;
            exp_so[i] = 1'b0; exp_dout[i] = 8'h00; last_accept[i] = 0;
        end
        step();
        step();
        idle_checks(0, "rst0");
        idle_checks(1, "rst1");
        @(negedge clk);
        rst = 1'b1;
        step();
        idle_checks(0, "rel0");

        // Full word, DIV=1: SI stream 0,0,1,1,1,1,0,0 (bit k-1 = shift k).
        xfer(0, 8'hA5, 4'd0, 8'b0011_1100, 0, 1'b0, 1'b0, 0);
        chk("a5_dout_const", dout[0], 8'h3C);

        // Partial length, DIV=2: SI stream 1,0,1.
        xfer(1, 8'hE0, 4'd3, 8'b0000_0101, 0, 1'b0, 1'b0, 0);
        chk("e0_dout_const", dout[1], 8'h05);

        // Oversized len behaves as a full word.
        xfer(0, 8'h5C, 4'd15, 8'hC3, 0, 1'b0, 1'b0, 0);
        xfer(1, 8'h96, 4'd9, 8'h6A, 0, 1'b0, 1'b0, 0);

        // Abort on the 4th tick: no shift, no done, dout retained.
        xfer(0, 8'hF0, 4'd0, 8'h55, 4, 1'b0, 1'b0, 0);
        xfer(1, 8'h3B, 4'd0, 8'hAA, 4, 1'b0, 1'b0, 0);

        // abort ignored both alongside the accept and during DONE.
        xfer(0, 8'h69, 4'd5, 8'h1B, 0, 1'b0, 1'b1, 0);

        // Back-to-back with start_valid held: second accept 10 cycles later.
        xfer(0, 8'h81, 4'd0, 8'h99, 0, 1'b1, 1'b0, 0);
        xfer(0, 8'h7E, 4'd0, 8'h42, 0, 1'b0, 1'b0, 10);

        // Randomized transfers on both instances.
        for (int i = 0; i < 40; i++) begin
            d     = i % 2;
            wd    = 8'($urandom_range(0, 255));
            ln    = 4'($urandom_range(0, 15));
            sib   = 8'($urandom_range(0, 255));
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            xfer(d, wd, ln, sib, ab_at, 1'b0, 1'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of a DIV=1 transfer, three bits in.
        sv[0] = 1'b1; din[0] = 8'hA5; len[0] = 4'd0;
        step();
        sv[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            si[0] = 1'b1;
            step();
        end
        chk("mid_busy_pre", bz[0], 1'b1);
        rst = 1'b0;
        #1;
        exp_so[0] = 1'b0; exp_dout[0] = 8'h00;
        exp_so[1] = 1'b0; exp_dout[1] = 8'h00;
        idle_checks(0, "midrst0");
        idle_checks(1, "midrst1");
        @(negedge clk);
        rst = 1'b1;
        step();
        idle_checks(0, "midrel");
        step();
        idle_checks(0, "midrel2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
